// File: rtl/regs_pkg.sv
// Shared constants and the read-port selection helper for the RV32I register file.
package regs_pkg;

  localparam int          RegNum       = 32;
  localparam int          RegAddrW     = 5;
  localparam int          DataW        = 32;
  localparam logic [31:0] ZeroWord     = 32'h0;
  localparam logic [4:0]  ZeroReg      = 5'h0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [4:0]  TestDoneReg  = 5'd26;
  localparam logic [4:0]  TestPassReg  = 5'd27;

  // x0 wins over bypass, so a write aimed at x0 can never leak onto a read port.
  function automatic logic [DataW-1:0] read_mux(
    input logic [RegAddrW-1:0] addr,
    input logic                wen,
    input logic [RegAddrW-1:0] waddr,
    input logic [DataW-1:0]    wdata,
    input logic [DataW-1:0]    stored
  );
    if (addr == ZeroReg)
      return ZeroWord;
    else if (wen == WriteEnable && waddr == addr)
      return wdata;
    else
      return stored;
  endfunction

endpackage

// File: rtl/regs.sv
// General-purpose register file with two bypassed read ports, a registered
// debug read port and a sticky riscv-tests pass/fail monitor.
module regs
  import regs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [RegAddrW-1:0] reg1_raddr_i,
  input  logic [RegAddrW-1:0] reg2_raddr_i,
  output logic [DataW-1:0]    reg1_rdata_o,
  output logic [DataW-1:0]    reg2_rdata_o,
  input  logic [RegAddrW-1:0] reg_waddr_i,
  input  logic [DataW-1:0]    reg_wdata_i,
  input  logic                reg_wen_i,
  input  logic [RegAddrW-1:0] dbg_raddr_i,
  output logic [DataW-1:0]    dbg_rdata_o,
  output logic                test_done_o,
  output logic                test_pass_o
);

  logic [DataW-1:0] reg_file [RegNum];
  logic [DataW-1:0] pass_visible;
  logic             done_write;

  assign reg1_rdata_o = read_mux(reg1_raddr_i, reg_wen_i, reg_waddr_i, reg_wdata_i,
                                 reg_file[reg1_raddr_i]);
  assign reg2_rdata_o = read_mux(reg2_raddr_i, reg_wen_i, reg_waddr_i, reg_wdata_i,
                                 reg_file[reg2_raddr_i]);

  // Pass register as the core would see it this cycle, bypass included.
  assign pass_visible = read_mux(TestPassReg, reg_wen_i, reg_waddr_i, reg_wdata_i,
                                 reg_file[TestPassReg]);

  assign done_write = (reg_wen_i == WriteEnable) && (reg_waddr_i == TestDoneReg)
                      && (reg_wdata_i != ZeroWord);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegNum; i++)
        reg_file[i] <= ZeroWord;
      dbg_rdata_o <= ZeroWord;
      test_done_o <= 1'b0;
      test_pass_o <= 1'b0;
    end else begin
      if (reg_wen_i == WriteEnable && reg_waddr_i != ZeroReg)
        reg_file[reg_waddr_i] <= reg_wdata_i;

      // Debug sees the pre-write contents; no bypass on this port.
      dbg_rdata_o <= (dbg_raddr_i == ZeroReg) ? ZeroWord : reg_file[dbg_raddr_i];

      if (!test_done_o && done_write) begin
        test_done_o <= 1'b1;
        test_pass_o <= (pass_visible == 32'd1);
      end
    end
  end

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: directed plan followed by random traffic
// compared against an array-based reference model.
module tb_regs;
  import regs_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, dbg_raddr_i;
  logic [31:0] reg1_rdata_o, reg2_rdata_o, reg_wdata_i, dbg_rdata_o;
  logic        reg_wen_i;
  logic        test_done_o, test_pass_o;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] model [32];
  logic [31:0] exp_dbg;
  logic        exp_done, exp_pass;

  regs dut (
    .clk          (clk),
    .rst          (rst),
    .reg1_raddr_i (reg1_raddr_i),
    .reg2_raddr_i (reg2_raddr_i),
    .reg1_rdata_o (reg1_rdata_o),
    .reg2_rdata_o (reg2_rdata_o),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_wen_i    (reg_wen_i),
    .dbg_raddr_i  (dbg_raddr_i),
    .dbg_rdata_o  (dbg_rdata_o),
    .test_done_o  (test_done_o),
    .test_pass_o  (test_pass_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Value a combinational read port should show this cycle.
  function automatic logic [31:0] expRead(input logic [4:0] addr);
    if (addr == 0) return 32'h0;
    if (reg_wen_i && reg_waddr_i == addr) return reg_wdata_i;
    return model[addr];
  endfunction

  // One clock cycle: drive, check combinational ports, clock, check registered outputs.
  task automatic applyStimulus(input logic r, input logic wen, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] da);
    @(negedge clk);
    rst = r; reg_wen_i = wen; reg_waddr_i = waddr; reg_wdata_i = wdata;
    reg1_raddr_i = a1; reg2_raddr_i = a2; dbg_raddr_i = da;
    #1;
    checkOutput("rd1", reg1_rdata_o, expRead(a1));
    checkOutput("rd2", reg2_rdata_o, expRead(a2));
    @(posedge clk);
    if (r) begin
      foreach (model[i]) model[i] = 32'h0;
      exp_dbg = 32'h0; exp_done = 1'b0; exp_pass = 1'b0;
    end else begin
      exp_dbg = model[da];
      if (!exp_done && wen && waddr == TestDoneReg && wdata != 0) begin
        exp_done = 1'b1;
        exp_pass = (expRead(TestPassReg) == 32'd1);
      end
      if (wen && waddr != 0) model[waddr] = wdata;
    end
    #1;
    checkOutput("dbg", dbg_rdata_o, exp_dbg);
    checkOutput("done", {31'b0, test_done_o}, {31'b0, exp_done});
    checkOutput("pass", {31'b0, test_pass_o}, {31'b0, exp_pass});
  endtask

  initial begin
    logic [4:0] wa;
    rst = 1'b1; reg_wen_i = 1'b0; reg_waddr_i = 0; reg_wdata_i = 0;
    reg1_raddr_i = 0; reg2_raddr_i = 0; dbg_raddr_i = 0;
    repeat (2) @(posedge clk);
    foreach (model[i]) model[i] = 32'h0;
    exp_dbg = 0; exp_done = 0; exp_pass = 0;

    // Everything reads zero after reset.
    for (int i = 0; i < 32; i++)
      applyStimulus(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));

    applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 5, 5, 5);
    checkOutput("dbg_x5_direct", dbg_rdata_o, 32'hDEADBEEF);

    // Same-cycle bypass on both ports; debug still sees the old value.
    applyStimulus(0, 1, 7, 32'h12345678, 7, 7, 7);
    checkOutput("dbg_x7_old", dbg_rdata_o, 32'h0);

    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 1, TestPassReg, 1, 0, 0, 0);
    applyStimulus(0, 1, TestDoneReg, 1, TestPassReg, TestDoneReg, 0);
    checkOutput("done_set", {31'b0, test_done_o}, 32'd1);
    checkOutput("pass_set", {31'b0, test_pass_o}, 32'd1);
    applyStimulus(0, 1, TestPassReg, 0, 0, 0, 0);
    applyStimulus(0, 1, TestDoneReg, 5, 0, 0, 0);

    // Reset wins over a concurrent write and a debug read.
    applyStimulus(0, 1, 9, 32'hA5A5A5A5, 9, 0, 0);
    applyStimulus(1, 1, 10, 32'h55, 9, 10, 9);
    checkOutput("dbg_rst", dbg_rdata_o, 32'h0);
    applyStimulus(0, 0, 0, 0, 9, 10, 10);

    // Random traffic, biased toward the monitor registers, with occasional reset.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0:       wa = TestDoneReg;
        1:       wa = TestPassReg;
        default: wa = 5'($urandom_range(0, 31));
      endcase
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), wa,
                    ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 2)) : $urandom,
                    ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                    5'($urandom), 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
